// File: rtl/clock_pkg.sv
// Time-field widths, limits and set-mode states shared by the
// key controller and the timekeeper.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

    // Encoding doubles as the display blink select
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HOUR = 2'b01,
        ST_MIN  = 2'b10,
        ST_SEC  = 2'b11
    } set_state_t;

    function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
        return (h >= HOUR_MAX) ? '0 : h + 5'd1;
    endfunction

    function automatic logic [MIN_W-1:0] sixty_inc(input logic [MIN_W-1:0] v);
        return (v >= MIN_MAX) ? '0 : v + 6'd1;
    endfunction

    function automatic logic [HOUR_W-1:0] hour_clamp(input logic [HOUR_W-1:0] h);
        return (h > HOUR_MAX) ? '0 : h;
    endfunction

    function automatic logic [MIN_W-1:0] sixty_clamp(input logic [MIN_W-1:0] v);
        return (v > MIN_MAX) ? '0 : v;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, debounce counter and a
// registered one-cycle pulse on each accepted press.
module key_debounce #(
    parameter int DB_CYCLES = 1000,
    parameter int CNT_W     = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic key_in,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             stable;
    logic             stable_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a   <= 1'b0;
            sync_b   <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            press    <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_a   <= key_in;
            sync_b   <= sync_a;
            stable_q <= stable;
            press    <= stable & ~stable_q;
            // Any sample agreeing with the accepted level restarts the count
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_b;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign level = stable;

endmodule

// File: rtl/clock_key_ctrl.sv
// Button front end and time-setting FSM: pauses the timekeeper, edits
// shadow h/m/s and hands them back with a one-cycle load strobe.
module clock_key_ctrl
    import clock_pkg::*;
#(
    parameter int DB_CYCLES     = 1000,
    parameter int REPEAT_DELAY  = 20000,
    parameter int REPEAT_PERIOD = 5000,
    parameter int CNT_W         = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              key_mode_in,
    input  logic              key_add_in,
    input  logic [HOUR_W-1:0] hour_in,
    input  logic [MIN_W-1:0]  minute_in,
    input  logic [SEC_W-1:0]  second_in,
    output logic              run_en,
    output logic [1:0]        field_sel,
    output logic              set_valid,
    output logic [HOUR_W-1:0] set_hour,
    output logic [MIN_W-1:0]  set_minute,
    output logic [SEC_W-1:0]  set_second
);

    // Fire is registered one cycle ahead, so compare against interval-2
    localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 2);
    localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 2);

    logic mode_press;
    logic mode_level_unused;
    logic add_press;
    logic add_level;

    key_debounce #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) u_mode_key (
        .clock (clock),
        .reset (reset),
        .key_in(key_mode_in),
        .level (mode_level_unused),
        .press (mode_press)
    );

    key_debounce #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) u_add_key (
        .clock (clock),
        .reset (reset),
        .key_in(key_add_in),
        .level (add_level),
        .press (add_press)
    );

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_fire;
    logic             rpt_steady;
    logic             mode_evt;
    logic             add_evt;

    assign mode_evt = mode_press;
    assign add_evt  = add_press | rpt_fire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_cnt    <= '0;
            rpt_fire   <= 1'b0;
            rpt_steady <= 1'b0;
        end else if (!add_level) begin
            rpt_cnt    <= '0;
            rpt_fire   <= 1'b0;
            rpt_steady <= 1'b0;
        end else if (add_evt) begin
            rpt_cnt    <= '0;
            rpt_fire   <= 1'b0;
            rpt_steady <= rpt_fire;
        end else begin
            rpt_cnt  <= rpt_cnt + CNT_W'(1);
            rpt_fire <= (rpt_cnt == (rpt_steady ? RPT_NEXT : RPT_FIRST));
        end
    end

    set_state_t        state;
    set_state_t        state_d;
    logic [HOUR_W-1:0] hour_d;
    logic [MIN_W-1:0]  minute_d;
    logic [SEC_W-1:0]  second_d;
    logic              valid_d;

    always_comb begin
        state_d  = state;
        hour_d   = set_hour;
        minute_d = set_minute;
        second_d = set_second;
        valid_d  = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (mode_evt) begin
                    state_d  = ST_HOUR;
                    hour_d   = hour_clamp(hour_in);
                    minute_d = sixty_clamp(minute_in);
                    second_d = sixty_clamp(second_in);
                end
            end
            ST_HOUR: begin
                if (mode_evt)     state_d = ST_MIN;
                else if (add_evt) hour_d  = hour_inc(set_hour);
            end
            ST_MIN: begin
                if (mode_evt)     state_d  = ST_SEC;
                else if (add_evt) minute_d = sixty_inc(set_minute);
            end
            ST_SEC: begin
                if (mode_evt) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                end else if (add_evt) begin
                    second_d = sixty_inc(set_second);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            set_hour   <= '0;
            set_minute <= '0;
            set_second <= '0;
            set_valid  <= 1'b0;
            run_en     <= 1'b1;
        end else begin
            state      <= state_d;
            set_hour   <= hour_d;
            set_minute <= minute_d;
            set_second <= second_d;
            set_valid  <= valid_d;
            run_en     <= (state_d == ST_RUN);
        end
    end

    assign field_sel = state;

endmodule
